// File: rtl/raptor64_pkg.sv
// raptor64_pkg
// Shared definitions for the Raptor64 cache line-fill path:
//   - MCB command codes for the cmd FIFO interface.
//   - Fill engine state enumeration.
package raptor64_pkg;

    localparam logic [2:0] MCB_CMD_WR = 3'b000;
    localparam logic [2:0] MCB_CMD_RD = 3'b001;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StCmd  = 2'd1,
        StRead = 2'd2,
        StDone = 2'd3
    } fill_state_e;

endpackage

// File: rtl/raptor64_word_pack.sv
// raptor64_word_pack
// Packs consecutive 32-bit read-FIFO words into 64-bit line RAM beats.
// Even-indexed words are held in a low-half register; an odd-indexed word
// completes the beat, which is registered and strobed on the following cycle.
//
// Ports:
//   clk_i       system clock
//   rst_i       synchronous active-high reset
//   pop_i       a word is consumed this cycle
//   word_idx_i  index of the consumed word within the line
//   data_i      consumed word
//   wr_o        beat write strobe (one cycle after the odd-word pop)
//   wr_beat_o   beat index within the line
//   wr_dat_o    beat data, lower-addressed word in bits [31:0]
module raptor64_word_pack #(
    parameter int unsigned LINE_WORDS = 8,
    localparam int unsigned WW = $clog2(LINE_WORDS),
    localparam int unsigned BW = (LINE_WORDS > 2) ? $clog2(LINE_WORDS / 2) : 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          pop_i,
    input  logic [WW-1:0] word_idx_i,
    input  logic [31:0]   data_i,
    output logic          wr_o,
    output logic [BW-1:0] wr_beat_o,
    output logic [63:0]   wr_dat_o
);

    logic [31:0]   lo_q, lo_d;
    logic [63:0]   dat_q, dat_d;
    logic [BW-1:0] beat_q, beat_d;
    logic          wr_q, wr_d;

    always_comb begin
        lo_d   = lo_q;
        dat_d  = dat_q;
        beat_d = beat_q;
        wr_d   = 1'b0;
        if (pop_i) begin
            if (!word_idx_i[0]) begin
                lo_d = data_i;
            end else begin
                dat_d  = {data_i, lo_q};
                beat_d = BW'(word_idx_i >> 1);
                wr_d   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lo_q   <= '0;
            dat_q  <= '0;
            beat_q <= '0;
            wr_q   <= 1'b0;
        end else begin
            lo_q   <= lo_d;
            dat_q  <= dat_d;
            beat_q <= beat_d;
            wr_q   <= wr_d;
        end
    end

    assign wr_o      = wr_q;
    assign wr_beat_o = beat_q;
    assign wr_dat_o  = dat_q;

endmodule

// File: rtl/raptor64_mcb_line_fill.sv
// raptor64_mcb_line_fill
// Cache line-fill engine. On a miss request it issues one line-aligned burst
// read on the MCB command FIFO, drains LINE_WORDS words from the read FIFO,
// packs them into 64-bit beats for the line RAM and pulses done_o.
//
// Optional feature macro: RAPTOR64_FILL_TIMEOUT_EN
//   When defined, an empty-FIFO watchdog aborts the fill after TIMEOUT
//   consecutive empty READ cycles, pulsing err_o with done_o.
//
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   req_i, req_adr_i    fill request and miss address (sampled in IDLE)
//   busy_o              not IDLE
//   done_o, err_o       completion / abort pulses
//   cmd_en, cmd_instr, cmd_bl, cmd_byte_addr, cmd_full   MCB command port
//   rd_en, rd_data, rd_empty                             MCB read port
//   wr_o, wr_beat_o, wr_dat_o                            line RAM write port
module raptor64_mcb_line_fill
    import raptor64_pkg::*;
#(
    parameter int unsigned LINE_WORDS = 8,
    parameter int unsigned TIMEOUT    = 1023,
    localparam int unsigned BW = (LINE_WORDS > 2) ? $clog2(LINE_WORDS / 2) : 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          req_i,
    input  logic [63:0]   req_adr_i,
    output logic          busy_o,
    output logic          done_o,
    output logic          err_o,
    output logic          cmd_en,
    output logic [2:0]    cmd_instr,
    output logic [5:0]    cmd_bl,
    output logic [29:0]   cmd_byte_addr,
    input  logic          cmd_full,
    output logic          rd_en,
    input  logic [31:0]   rd_data,
    input  logic          rd_empty,
    output logic          wr_o,
    output logic [BW-1:0] wr_beat_o,
    output logic [63:0]   wr_dat_o
);

    localparam int unsigned WW = $clog2(LINE_WORDS);
    localparam logic [29:0] AddrMask = 30'(LINE_WORDS * 4 - 1);
    localparam logic [WW-1:0] LastWord = WW'(LINE_WORDS - 1);

    fill_state_e   state_q, state_d;
    logic [WW-1:0] wcnt_q, wcnt_d;
    logic [29:0]   addr_q, addr_d;

`ifdef RAPTOR64_FILL_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TmoLast = TW'(TIMEOUT - 1);

    logic [TW-1:0] tmo_q, tmo_d;
    logic          err_q, err_d;
`endif

    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        addr_d  = addr_q;
        cmd_en  = 1'b0;
        rd_en   = 1'b0;
`ifdef RAPTOR64_FILL_TIMEOUT_EN
        tmo_d   = tmo_q;
        err_d   = err_q;
`endif
        unique case (state_q)
            StIdle: begin
`ifdef RAPTOR64_FILL_TIMEOUT_EN
                tmo_d = '0;
                err_d = 1'b0;
`endif
                if (req_i) begin
                    addr_d  = req_adr_i[29:0] & ~AddrMask;
                    wcnt_d  = '0;
                    state_d = StCmd;
                end
            end
            StCmd: begin
                cmd_en = !cmd_full;
                if (!cmd_full) begin
                    state_d = StRead;
                end
            end
            StRead: begin
                rd_en = !rd_empty;
                if (!rd_empty) begin
                    wcnt_d = wcnt_q + 1'b1;
                    if (wcnt_q == LastWord) begin
                        state_d = StDone;
                    end
`ifdef RAPTOR64_FILL_TIMEOUT_EN
                    tmo_d = '0;
                end else if (tmo_q == TmoLast) begin
                    // Watchdog expiry: abort; beats already written stay written.
                    state_d = StDone;
                    err_d   = 1'b1;
                end else begin
                    tmo_d = tmo_q + 1'b1;
`endif
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
        // No pushes or pops in the reset cycle; the FIFOs are being flushed too.
        if (rst_i) begin
            cmd_en = 1'b0;
            rd_en  = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            wcnt_q  <= '0;
            addr_q  <= '0;
`ifdef RAPTOR64_FILL_TIMEOUT_EN
            tmo_q   <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            addr_q  <= addr_d;
`ifdef RAPTOR64_FILL_TIMEOUT_EN
            tmo_q   <= tmo_d;
            err_q   <= err_d;
`endif
        end
    end

    raptor64_word_pack #(
        .LINE_WORDS (LINE_WORDS)
    ) u_pack (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .pop_i      (rd_en),
        .word_idx_i (wcnt_q),
        .data_i     (rd_data),
        .wr_o       (wr_o),
        .wr_beat_o  (wr_beat_o),
        .wr_dat_o   (wr_dat_o)
    );

    assign busy_o        = (state_q != StIdle);
    assign done_o        = (state_q == StDone);
    assign cmd_instr     = MCB_CMD_RD;
    assign cmd_bl        = 6'(LINE_WORDS - 1);
    assign cmd_byte_addr = addr_q;

`ifdef RAPTOR64_FILL_TIMEOUT_EN
    assign err_o = (state_q == StDone) && err_q;
`else
    assign err_o = 1'b0;
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT;
`endif

    // Only the 30-bit MCB byte address range is used.
    logic unused_adr;
    assign unused_adr = ^req_adr_i[63:30];

endmodule

// File: tb/tb_raptor64_mcb_line_fill.sv
// Self-checking bench for raptor64_mcb_line_fill (LINE_WORDS = 8).
// Defines RAPTOR64_FILL_TIMEOUT_EN to also exercise the watchdog (TIMEOUT = 16).
module tb_raptor64_mcb_line_fill;

    localparam int unsigned LW = 8;
`ifdef RAPTOR64_FILL_TIMEOUT_EN
    localparam int unsigned TMO = 16;
`else
    localparam int unsigned TMO = 1023;
`endif

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        req_i = 1'b0;
    logic [63:0] req_adr_i = '0;
    logic        busy_o, done_o, err_o;
    logic        cmd_en;
    logic [2:0]  cmd_instr;
    logic [5:0]  cmd_bl;
    logic [29:0] cmd_byte_addr;
    logic        cmd_full = 1'b0;
    logic        rd_en;
    logic [31:0] rd_data = '0;
    logic        rd_empty = 1'b1;
    logic        wr_o;
    logic [1:0]  wr_beat_o;
    logic [63:0] wr_dat_o;

    raptor64_mcb_line_fill #(
        .LINE_WORDS (LW),
        .TIMEOUT    (TMO)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .req_i         (req_i),
        .req_adr_i     (req_adr_i),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .err_o         (err_o),
        .cmd_en        (cmd_en),
        .cmd_instr     (cmd_instr),
        .cmd_bl        (cmd_bl),
        .cmd_byte_addr (cmd_byte_addr),
        .cmd_full      (cmd_full),
        .rd_en         (rd_en),
        .rd_data       (rd_data),
        .rd_empty      (rd_empty),
        .wr_o          (wr_o),
        .wr_beat_o     (wr_beat_o),
        .wr_dat_o      (wr_dat_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [1:0]  beat;
        logic [63:0] dat;
    } beat_t;

    typedef struct {
        int cyc;
        bit err;
    } done_t;

    logic [29:0] exp_cmd_q[$];
    beat_t       exp_beat_q[$];
    done_t       exp_done_q[$];

    int vectors = 0;
    int miscompares = 0;
    int fills_done = 0;
    int pops = 0;
    int stall_mode = 0;
    int supply_limit = LW;
    logic [31:0] salt = 32'h1234_5678;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Memory contents as a function of byte address.
    function automatic logic [31:0] mem_word(input logic [29:0] a);
        return ({2'b00, a} * 32'h9E37_79B1) ^ salt;
    endfunction

    // MCB port model: a burst read command returns the words of the line in order.
    initial begin : fifo_model
        logic [31:0] fifo_q[$];
        logic        do_pop, do_push, rst_s, tog;
        logic [29:0] addr_s;
        tog = 1'b0;
        forever begin
            @(negedge clk);
            do_pop  = rd_en && !rd_empty;
            do_push = cmd_en;
            addr_s  = cmd_byte_addr;
            rst_s   = rst_i;
            if (do_pop) pops++;
            @(posedge clk);
            #1;
            if (rst_s) begin
                fifo_q.delete();
            end else begin
                if (do_pop && fifo_q.size() > 0) void'(fifo_q.pop_front());
                if (do_push) begin
                    for (int i = 0; i < supply_limit; i++) begin
                        fifo_q.push_back(mem_word(addr_s + 30'(4 * i)));
                    end
                end
            end
            tog = ~tog;
            case (stall_mode)
                1:       rd_empty = (fifo_q.size() == 0) || ($urandom_range(0, 1) == 1);
                2:       rd_empty = (fifo_q.size() == 0) || tog;
                default: rd_empty = (fifo_q.size() == 0);
            endcase
            rd_data = (fifo_q.size() > 0) ? fifo_q[0] : 32'h0;
        end
    end

    // Monitor: compares every DUT output event against the scoreboard queues.
    always @(negedge clk) begin
        if (!rst_i) begin
            if (cmd_en) begin
                check("cmd_expected", 64'(exp_cmd_q.size() > 0), 64'd1);
                check("cmd_while_full", 64'(cmd_full), 64'd0);
                check("cmd_bl", 64'(cmd_bl), 64'(LW - 1));
                check("cmd_instr", 64'(cmd_instr), 64'd1);
                if (exp_cmd_q.size() > 0) check("cmd_addr", 64'(cmd_byte_addr), 64'(exp_cmd_q.pop_front()));
            end
            if (rd_en) check("pop_while_empty", 64'(rd_empty), 64'd0);
            if (wr_o) begin
                check("beat_expected", 64'(exp_beat_q.size() > 0), 64'd1);
                if (exp_beat_q.size() > 0) begin
                    beat_t b;
                    b = exp_beat_q.pop_front();
                    check("wr_beat", 64'(wr_beat_o), 64'(b.beat));
                    check("wr_dat", wr_dat_o, b.dat);
                end
            end
            if (err_o && !done_o) check("err_without_done", 64'(err_o), 64'd0);
            if (done_o) begin
                check("done_expected", 64'(exp_done_q.size() > 0), 64'd1);
                if (exp_done_q.size() > 0) begin
                    done_t d;
                    d = exp_done_q.pop_front();
                    check("err_o", 64'(err_o), 64'(d.err));
                    if (d.cyc >= 0) check("done_cycle", 64'(cyc), 64'(d.cyc));
                end
                check("beats_left_at_done", 64'(exp_beat_q.size()), 64'd0);
                fills_done++;
            end
        end
    end

    // One complete fill; called at posedge+1 with the DUT idle.
    task automatic fill(input logic [63:0] adr, input int nfull, input int stall,
                        input int limit);
        logic [29:0] base;
        done_t       d;
        int          t0, target, n;
        bit          will_err;
        salt = $urandom;
        base = adr[29:0] & ~30'(LW * 4 - 1);
        will_err = (limit < LW);
        exp_cmd_q.push_back(base);
        for (int k = 0; k < LW / 2; k++) begin
            if (2 * k + 1 < limit) begin
                exp_beat_q.push_back({2'(k), mem_word(base + 30'(8 * k + 4)),
                                      mem_word(base + 30'(8 * k))});
            end
        end
        t0 = cyc;
        d.err = will_err;
        if (stall != 0) d.cyc = -1;
        else if (will_err) d.cyc = t0 + 2 + nfull + limit + int'(TMO);
        else d.cyc = t0 + 2 + nfull + LW;
        exp_done_q.push_back(d);
        stall_mode   = stall;
        supply_limit = limit;
        req_adr_i    = adr;
        req_i        = 1'b1;
        target       = fills_done + 1;
        if (nfull > 0) begin
            cmd_full = 1'b1;
            repeat (nfull + 1) @(posedge clk);
            #1;
            cmd_full = 1'b0;
        end
        n = 0;
        while (fills_done < target && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("fill_completes", 64'(fills_done >= target), 64'd1);
        req_i        = 1'b0;
        stall_mode   = 0;
        supply_limit = LW;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"}, 64'(busy_o), 64'd0);
        check({tag, "_strobes"}, 64'({cmd_en, rd_en, wr_o, done_o, err_o}), 64'd0);
        check({tag, "_addr"}, 64'(cmd_byte_addr), 64'd0);
        check({tag, "_wdat"}, wr_dat_o, 64'd0);
        check({tag, "_wbeat"}, 64'(wr_beat_o), 64'd0);
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        int n, p0;
        repeat (3) @(posedge clk);
        #1;
        rst_i = 1'b0;
        check_idle_outputs("reset");

        // Basic fill with the FIFO always non-empty.
        fill(64'hFFFF_FFFF_FFFF_F01C, 0, 0, LW);
        // Command FIFO full for 5 cycles.
        fill(64'h0000_0000_1234_5678, 5, 0, LW);
        // Read FIFO empty every other cycle.
        fill(64'h0000_0000_0ABC_DE40, 0, 2, LW);

        // Reset in READ after 3 pops.
        salt = $urandom;
        exp_cmd_q.push_back(30'h0000_0100);
        exp_beat_q.push_back({2'd0, mem_word(30'h0000_0104), mem_word(30'h0000_0100)});
        req_adr_i = 64'h0000_0000_0000_0108;
        req_i = 1'b1;
        p0 = pops;
        n = 0;
        while (pops < p0 + 3 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("pops_before_reset", 64'(pops - p0), 64'd3);
        rst_i = 1'b1;
        req_i = 1'b0;
        @(posedge clk);
        #1;
        rst_i = 1'b0;
        check_idle_outputs("mid_reset");
        check("reset_cmd_q", 64'(exp_cmd_q.size()), 64'd0);
        check("reset_beat_q", 64'(exp_beat_q.size()), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        check("reset_no_pops", 64'(pops - p0), 64'd3);
        fill(64'h0000_0000_3000_0020, 0, 0, LW);

        // Request coincident with reset is dropped.
        rst_i = 1'b1;
        req_i = 1'b1;
        @(posedge clk);
        #1;
        rst_i = 1'b0;
        req_i = 1'b0;
        check("req_with_rst_busy", 64'(busy_o), 64'd0);
        @(posedge clk);
        #1;
        check("req_with_rst_busy2", 64'(busy_o), 64'd0);

        // Back-to-back fills with req_i held through DONE.
        fill(64'h0000_0000_0000_0040, 0, 0, LW);
        req_i = 1'b1;
        fill(64'h0000_0000_0000_0080, 0, 0, LW);

`ifdef RAPTOR64_FILL_TIMEOUT_EN
        // Only 2 words supplied: watchdog abort with a single beat written.
        fill(64'h0000_0000_2222_2200, 0, 0, 2);
        fill(64'h0000_0000_2222_2300, 0, 0, LW);
`endif

        // Randomized fills.
        for (int i = 0; i < 25; i++) begin
            fill({$urandom, $urandom}, int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), LW);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
        end

        repeat (5) @(posedge clk);
        #1;
        check("final_cmd_q", 64'(exp_cmd_q.size()), 64'd0);
        check("final_beat_q", 64'(exp_beat_q.size()), 64'd0);
        check("final_done_q", 64'(exp_done_q.size()), 64'd0);
        check("final_busy", 64'(busy_o), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
